// File: rtl/dbus_lane_sequencer_pkg.sv
// Shared types for the dual-lane dbus sequencer: bus request/response structs,
// memory-size encoding, sequencer FSM states and the alignment helper.
package dbus_lane_sequencer_pkg;

  localparam int DBUS_ADDR_W = 32;
  localparam int DBUS_DATA_W = 32;

  typedef enum logic [1:0] {
    MSIZE_BYTE = 2'd0,
    MSIZE_HALF = 2'd1,
    MSIZE_WORD = 2'd2
  } msize_t;

  typedef struct packed {
    logic                   valid;
    logic [DBUS_ADDR_W-1:0] addr;
    msize_t                 size;
    logic [3:0]             strobe;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic                   addr_ok;
    logic                   data_ok;
    logic [DBUS_DATA_W-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    DSEQ_IDLE = 2'd0,
    DSEQ_REQ  = 2'd1,
    DSEQ_WAIT = 2'd2,
    DSEQ_DONE = 2'd3
  } dseq_state_t;

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    is_misaligned = ((size == 2'(MSIZE_HALF)) && addr_lo[0]) ||
                    ((size == 2'(MSIZE_WORD)) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dbus_req_mux.sv
// Combinational selection of the latched fields of lane idx onto the dbus request.
// Loads are presented with a zero strobe and zero data; stores carry their strobe and data.
module dbus_req_mux
  import dbus_lane_sequencer_pkg::*;
#(
  parameter int ADDR_W = DBUS_ADDR_W,
  parameter int DATA_W = DBUS_DATA_W
) (
  input  logic                active,
  input  logic                idx,
  input  logic [1:0]          wr,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [3:0]          size,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [7:0]          strobe,
  output dbus_req_t           dreq
);

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_strobe;

  always_comb begin
    sel_wr     = idx ? wr[1]                  : wr[0];
    sel_addr   = idx ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    sel_size   = idx ? size[3:2]              : size[1:0];
    sel_wdata  = idx ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    sel_strobe = idx ? strobe[7:4]            : strobe[3:0];
  end

  always_comb begin
    dreq        = '0;
    dreq.valid  = active;
    dreq.addr   = sel_addr;
    dreq.size   = msize_t'(sel_size);
    dreq.strobe = sel_wr ? sel_strobe : 4'h0;
    dreq.data   = sel_wr ? sel_wdata  : '0;
  end

endmodule

// File: rtl/dbus_lane_sequencer.sv
// Serialises the memory ops of a dual-issue bundle onto the single dbus, lane 0 first.
// Optional feature macro DBUS_SEQ_MISALIGN_EN: flags misaligned lanes on misalign[] and skips them.
module dbus_lane_sequencer
  import dbus_lane_sequencer_pkg::*;
#(
  parameter int ADDR_W = DBUS_ADDR_W,
  parameter int DATA_W = DBUS_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          lane_valid,
  input  logic [1:0]          lane_wr,
  input  logic [2*ADDR_W-1:0] lane_addr,
  input  logic [3:0]          lane_size,
  input  logic [2*DATA_W-1:0] lane_wdata,
  input  logic [7:0]          lane_strobe,
  input  logic                flush,
  output dbus_req_t           dreq,
  input  dbus_resp_t          dresp,
  output logic                stall,
  output logic [2*DATA_W-1:0] rdata,
  output logic                done,
`ifdef DBUS_SEQ_MISALIGN_EN
  output logic [1:0]          misalign,
`endif
  output dseq_state_t         fsm_state
);

  // Bus handshake: dreq.valid rises in REQ and its fields hold until a cycle with
  // dresp.addr_ok (request accepted); dresp.data_ok ends the transaction and may
  // coincide with addr_ok. Only one transaction is ever outstanding.

  dseq_state_t         state, state_next;
  logic                idx, idx_next;
  logic                kill;
  logic                kill_now;
  logic                start;
  logic [1:0]          start_issue;
  logic                complete;
  logic                cur_wr;
  logic                req_active;

  logic [1:0]          wr_q;
  logic [2*ADDR_W-1:0] addr_q;
  logic [3:0]          size_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [7:0]          strobe_q;
  logic                lane1_go_q;

  assign start = (|lane_valid) && !flush;

`ifdef DBUS_SEQ_MISALIGN_EN
  logic [1:0] mis;
  logic [1:0] misalign_q;

  assign mis[0] = lane_valid[0] && is_misaligned(lane_size[1:0], lane_addr[1:0]);
  assign mis[1] = lane_valid[1] && is_misaligned(lane_size[3:2], lane_addr[ADDR_W+1:ADDR_W]);
  // A bad lane 0 takes lane 1 down with it to keep program order intact.
  assign start_issue = {lane_valid[1] && !mis[1] && !mis[0], lane_valid[0] && !mis[0]};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      misalign_q <= 2'b00;
    end else if (state_next == DSEQ_IDLE) begin
      misalign_q <= 2'b00;
    end else if (state == DSEQ_IDLE && start) begin
      misalign_q <= mis;
    end
  end

  assign misalign = misalign_q;
`else
  assign start_issue = lane_valid;
`endif

  // A flush arriving in the completing cycle counts just like a registered one.
  assign kill_now = kill || flush;
  assign cur_wr   = idx ? wr_q[1] : wr_q[0];

  always_comb begin
    state_next = state;
    idx_next   = idx;
    complete   = 1'b0;
    case (state)
      DSEQ_IDLE: begin
        if (start) begin
          if (start_issue[0]) begin
            idx_next   = 1'b0;
            state_next = DSEQ_REQ;
          end else if (start_issue[1]) begin
            idx_next   = 1'b1;
            state_next = DSEQ_REQ;
          end else begin
            state_next = DSEQ_DONE;
          end
        end
      end
      DSEQ_REQ: begin
        if (dresp.addr_ok) begin
          if (dresp.data_ok) complete = 1'b1;
          else               state_next = DSEQ_WAIT;
        end
      end
      DSEQ_WAIT: begin
        if (dresp.data_ok) complete = 1'b1;
      end
      DSEQ_DONE: state_next = DSEQ_IDLE;
      default:   state_next = DSEQ_IDLE;
    endcase

    if (complete) begin
      if (kill_now) begin
        state_next = DSEQ_IDLE;
      end else if (!idx && lane1_go_q) begin
        idx_next   = 1'b1;
        state_next = DSEQ_REQ;
      end else begin
        state_next = DSEQ_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= DSEQ_IDLE;
      idx        <= 1'b0;
      kill       <= 1'b0;
      wr_q       <= 2'b00;
      addr_q     <= '0;
      size_q     <= 4'h0;
      wdata_q    <= '0;
      strobe_q   <= 8'h00;
      lane1_go_q <= 1'b0;
      rdata      <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;

      if (state == DSEQ_IDLE) begin
        kill <= 1'b0;
      end else if ((state == DSEQ_REQ || state == DSEQ_WAIT) && flush) begin
        kill <= 1'b1;
      end

      if (state == DSEQ_IDLE && start) begin
        wr_q       <= lane_wr;
        addr_q     <= lane_addr;
        size_q     <= lane_size;
        wdata_q    <= lane_wdata;
        strobe_q   <= lane_strobe;
        lane1_go_q <= start_issue[1];
      end

      if (complete && !cur_wr) begin
        if (idx) rdata[2*DATA_W-1:DATA_W] <= dresp.data;
        else     rdata[DATA_W-1:0]        <= dresp.data;
      end
    end
  end

  assign req_active = (state == DSEQ_REQ);

  dbus_req_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_mux (
    .active(req_active),
    .idx   (idx),
    .wr    (wr_q),
    .addr  (addr_q),
    .size  (size_q),
    .wdata (wdata_q),
    .strobe(strobe_q),
    .dreq  (dreq)
  );

  assign stall     = (state == DSEQ_IDLE && start) || (state == DSEQ_REQ) || (state == DSEQ_WAIT);
  assign done      = (state == DSEQ_DONE);
  assign fsm_state = state;

endmodule
